// File: rtl/serial_addsub_pkg.sv
// Shared constants for the bit-serial adder/subtractor: FSM state encoding and opcodes.
package serial_addsub_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_full_adder.sv
// One-bit full adder cell, used as the per-bit datapath of serial_addsub.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor: one bit per clock, LSB first, carry held in a flop.
// start/ready/done handshake; result, cout and ovf hold until the next completed operation.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic             carry_q,  carry_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q,   cout_d;
    logic             ovf_q,    ovf_d;

    logic fa_sum;
    logic fa_carry;

    full_adder u_fa (
        .a     (a_sh_q[0]),
        .b     (b_sh_q[0]),
        .cin   (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // Subtract is a + ~b + 1, the +1 entering as the initial carry.
                    a_sh_d   = a;
                    b_sh_d   = (op == OP_SUB) ? ~b : b;
                    carry_d  = op;
                    cnt_d    = '0;
                    res_sh_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                res_sh_d = {fa_sum, res_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                carry_d  = fa_carry;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // carry_q is the carry into the MSB here, so overflow is its xor with carry out.
                    result_d = {fa_sum, res_sh_q[WIDTH-1:1]};
                    cout_d   = fa_carry;
                    ovf_d    = carry_q ^ fa_carry;
                    cnt_d    = '0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ready  = (state_q == ST_IDLE);
    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub: WIDTH=8 handshake/arithmetic cases and a WIDTH=4
// exhaustive back-to-back sweep against an arithmetic reference.
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0, op8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ready8, busy8, done8, cout8, ovf8;
    logic [7:0] result8;

    logic       start4 = 1'b0, op4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       ready4, busy4, done4, cout4, ovf4;
    logic [3:0] result4;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_addsub #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .ready(ready8), .busy(busy8), .done(done8), .result(result8), .cout(cout8), .ovf(ovf8)
    );

    serial_addsub #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4),
        .ready(ready4), .busy(busy4), .done(done4), .result(result4), .cout(cout4), .ovf(ovf4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One WIDTH=8 operation; optionally pulses start with a=AA in the middle of RUN.
    task automatic run8(input string tag, input logic op, input logic [7:0] a, input logic [7:0] b,
                        input bit inject, input logic [7:0] exp_res, input logic exp_c,
                        input logic exp_v);
        int pulses = 0;
        int at = -1;
        logic rdy_after = 1'b0;
        logic [9:0] got = '0;
        @(negedge clk);
        start8 = 1'b1; op8 = op; a8 = a; b8 = b;
        @(posedge clk);
        #1 start8 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (inject && k == 3) begin start8 = 1'b1; a8 = 8'hAA; end
            if (inject && k == 4) start8 = 1'b0;
            if (done8) begin
                pulses++;
                if (at < 0) begin
                    at = k;
                    got = {cout8, ovf8, result8};
                end
            end
            if (k == 9) rdy_after = ready8;
        end
        chk({tag, "_done_edge"}, at, 8);
        chk({tag, "_done_count"}, pulses, 1);
        chk({tag, "_res_cout_ovf"}, got, {exp_c, exp_v, exp_res});
        chk({tag, "_ready_after"}, rdy_after, 1'b1);
        chk({tag, "_held"}, {cout8, ovf8, result8}, {exp_c, exp_v, exp_res});
        $display("op %s: op=%0d a=%h b=%h -> result=%h cout=%0d ovf=%0d", tag, op, a, b,
                 got[7:0], got[9], got[8]);
    endtask

    initial begin
        int last_done;
        int seen;
        int pulses;
        logic [4:0] sum;
        logic [3:0] bb, er;
        logic ev;

        // Reset state
        #2;
        chk("rst_ready", ready8, 1'b1);
        chk("rst_busy_done", {busy8, done8}, 2'b00);
        chk("rst_outputs", {cout8, ovf8, result8}, 10'h000);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        run8("add_0F_01", 1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        run8("add_7F_01", 1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("add_FF_01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("sub_05_07", 1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
        run8("sub_80_01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        run8("ign_start", 1'b0, 8'h03, 8'h04, 1'b1, 8'h07, 1'b0, 1'b0);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        start8 = 1'b1; op8 = 1'b0; a8 = 8'hFF; b8 = 8'h01;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {cout8, ovf8, result8}, 10'h000);
        chk("midrst_flags", {ready8, busy8, done8}, 3'b100);
        @(negedge clk) rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1 if (done8) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        chk("midrst_ready", ready8, 1'b1);
        $display("op mid_run_reset: done pulses after abort=%0d", pulses);

        // WIDTH=4 exhaustive sweep, start held high
        last_done = -1;
        @(negedge clk);
        op4 = 1'b0; a4 = 4'h0; b4 = 4'h0; start4 = 1'b1;
        for (int v = 0; v < 512; v++) begin
            seen = 0;
            for (int t = 0; t < 20 && seen == 0; t++) begin
                @(posedge clk);
                #1 if (done4) seen = 1;
            end
            if (seen == 0) begin
                chk("sweep_timeout", 0, 1);
                break;
            end
            bb  = op4 ? ~b4 : b4;
            sum = {1'b0, a4} + {1'b0, bb} + {4'b0, op4};
            er  = sum[3:0];
            ev  = op4 ? ((a4[3] != b4[3]) && (er[3] != a4[3]))
                      : ((a4[3] == b4[3]) && (er[3] != a4[3]));
            chk("sweep_res", {cout4, ovf4, result4}, {sum[4], ev, er});
            if (last_done >= 0) chk("sweep_interval", cyc - last_done, 6);
            $display("sweep op=%0d a=%h b=%h -> result=%h cout=%0d ovf=%0d", op4, a4, b4,
                     result4, cout4, ovf4);
            last_done = cyc;
            {op4, a4, b4} = 9'(v + 1);
        end
        start4 = 1'b0;
        repeat (8) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
